// File: rtl/char_fifo_if.sv
// rtl/char_fifo_if.sv - push/pop/status bundle between the character FIFO and its users
//
// Signals:
//   char_fifo_wr_en        push request
//   char_fifo_din          push data
//   char_fifo_full         occupancy == DEPTH
//   char_fifo_almost_full  occupancy >= AF_THRESH
//   char_fifo_rd_en        pop request, acknowledges the current head
//   char_fifo_dout         head data, valid while char_fifo_empty is low
//   char_fifo_empty        no valid head
//   char_fifo_count        occupancy, 0..DEPTH
//   char_fifo_clr_err      single-cycle clear of the sticky error flags
//   char_fifo_overflow     sticky: push attempted while full
//   char_fifo_underflow    sticky: pop attempted while empty
// Modports: master = producer/consumer side, slave = FIFO side.
interface char_fifo_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   logic                    char_fifo_wr_en;
   logic [DATA_W-1:0]       char_fifo_din;
   logic                    char_fifo_full;
   logic                    char_fifo_almost_full;
   logic                    char_fifo_rd_en;
   logic [DATA_W-1:0]       char_fifo_dout;
   logic                    char_fifo_empty;
   logic [$clog2(DEPTH):0]  char_fifo_count;
   logic                    char_fifo_clr_err;
   logic                    char_fifo_overflow;
   logic                    char_fifo_underflow;

   modport master (
      output char_fifo_wr_en, char_fifo_din, char_fifo_rd_en, char_fifo_clr_err,
      input  char_fifo_full, char_fifo_almost_full, char_fifo_dout, char_fifo_empty,
             char_fifo_count, char_fifo_overflow, char_fifo_underflow
   );

   modport slave (
      input  char_fifo_wr_en, char_fifo_din, char_fifo_rd_en, char_fifo_clr_err,
      output char_fifo_full, char_fifo_almost_full, char_fifo_dout, char_fifo_empty,
             char_fifo_count, char_fifo_overflow, char_fifo_underflow
   );
endinterface

// File: rtl/char_fifo.sv
// rtl/char_fifo.sv - first-word-fall-through character buffer feeding the UART transmitter
//
// Ports:
//   clk_tx        clock, all logic on the rising edge
//   rst_clk_tx_n  asynchronous active-low reset
//   fifo_if       char_fifo_if.slave: push/pop handshakes, head data, occupancy,
//                 full/almost-full/empty and sticky overflow/underflow flags
// All outputs are registered.
module char_fifo #(
   parameter int DEPTH     = 16,
   parameter int DATA_W    = 8,
   parameter int AF_THRESH = 12
) (
   input  logic        clk_tx,
   input  logic        rst_clk_tx_n,
   char_fifo_if.slave  fifo_if
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [DATA_W-1:0] r_dout;
   logic              r_empty;
   logic              r_full;
   logic              r_almost_full;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_push;
   logic              w_pop;
   logic [AW-1:0]     w_rd_ptr_nxt;
   logic [CW-1:0]     w_old_left;
   logic [CW-1:0]     w_count_nxt;

   assign w_push = fifo_if.char_fifo_wr_en & ~r_full;
   assign w_pop  = fifo_if.char_fifo_rd_en & ~r_empty;

   // w_old_left counts entries written before this edge that remain after a pop.
   // Only those can be presented next cycle; an entry pushed on this edge becomes
   // visible one edge later, which is where the single bubble cycle comes from.
   always_comb begin
      w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
      w_old_left   = r_count - CW'(w_pop);
      w_count_nxt  = w_old_left + CW'(w_push);
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk_tx) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= fifo_if.char_fifo_din;
      end
   end

   always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
      if (!rst_clk_tx_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_dout        <= '0;
         r_empty       <= 1'b1;
         r_full        <= 1'b0;
         r_almost_full <= 1'b0;
         r_overflow    <= 1'b0;
         r_underflow   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         r_rd_ptr      <= w_rd_ptr_nxt;
         r_count       <= w_count_nxt;
         r_full        <= (w_count_nxt == CW'(DEPTH));
         r_almost_full <= (w_count_nxt >= CW'(AF_THRESH));
         r_empty       <= (w_old_left == '0);
         // Reloading the head slot while no pop occurs is harmless: an occupied
         // slot cannot be overwritten, so dout stays stable. When nothing old is
         // left, dout simply holds its last value.
         if (w_old_left != '0) begin
            r_dout <= r_mem[w_rd_ptr_nxt];
         end
         // Set wins over clear when both happen in the same cycle.
         r_overflow  <= (fifo_if.char_fifo_wr_en & r_full) |
                        (r_overflow & ~fifo_if.char_fifo_clr_err);
         r_underflow <= (fifo_if.char_fifo_rd_en & r_empty) |
                        (r_underflow & ~fifo_if.char_fifo_clr_err);
      end
   end

   assign fifo_if.char_fifo_dout        = r_dout;
   assign fifo_if.char_fifo_empty       = r_empty;
   assign fifo_if.char_fifo_full        = r_full;
   assign fifo_if.char_fifo_almost_full = r_almost_full;
   assign fifo_if.char_fifo_count       = r_count;
   assign fifo_if.char_fifo_overflow    = r_overflow;
   assign fifo_if.char_fifo_underflow   = r_underflow;
endmodule

// File: tb/tb_char_fifo.sv
// tb/tb_char_fifo.sv - self-checking bench for char_fifo
module tb_char_fifo;
   localparam int DEPTH     = 16;
   localparam int DATA_W    = 8;
   localparam int AF_THRESH = 12;

   logic clk_tx       = 1'b0;
   logic rst_clk_tx_n = 1'b0;

   char_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fifo_bus ();

   char_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AF_THRESH(AF_THRESH)) dut (
      .clk_tx       (clk_tx),
      .rst_clk_tx_n (rst_clk_tx_n),
      .fifo_if      (fifo_bus)
   );

   always #5 clk_tx = ~clk_tx;

   typedef struct {
      logic       wr;
      logic [7:0] din;
      logic       rd;
      logic       clr;
      logic [4:0] count;
      logic       empty;
      logic       full;
      logic       af;
      logic       ovf;
      logic       unf;
      logic       chk_dout;
      logic [7:0] dout;
   } vec_t;

   vec_t vecs[14];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic wr, input logic [7:0] din, input logic rd, input logic clr);
      fifo_bus.char_fifo_wr_en   = wr;
      fifo_bus.char_fifo_din     = din;
      fifo_bus.char_fifo_rd_en   = rd;
      fifo_bus.char_fifo_clr_err = clr;
   endtask

   task automatic tick();
      @(posedge clk_tx);
      #1;
   endtask

   task automatic check_idle_state(input string tag);
      check({tag, ".count"}, fifo_bus.char_fifo_count, 0);
      check({tag, ".empty"}, fifo_bus.char_fifo_empty, 1);
      check({tag, ".full"},  fifo_bus.char_fifo_full, 0);
      check({tag, ".af"},    fifo_bus.char_fifo_almost_full, 0);
   endtask

   // Pushes base+0..base+15 into an empty FIFO, checking occupancy flags each edge.
   task automatic fill16(input logic [7:0] base);
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, base + 8'(i), 1'b0, 1'b0);
         tick();
         check($sformatf("fill%0d.count", i), fifo_bus.char_fifo_count, i + 1);
         check($sformatf("fill%0d.af", i),    fifo_bus.char_fifo_almost_full, (i + 1) >= AF_THRESH);
         check($sformatf("fill%0d.full", i),  fifo_bus.char_fifo_full, (i + 1) == DEPTH);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   // Pops n entries expecting base, base+1, ... in order.
   task automatic drain(input int n, input logic [7:0] base, input string tag);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s%0d.empty", tag, i), fifo_bus.char_fifo_empty, 0);
         check($sformatf("%s%0d.dout", tag, i),  fifo_bus.char_fifo_dout, base + 8'(i));
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         tick();
         check($sformatf("%s%0d.count", tag, i), fifo_bus.char_fifo_count, n - 1 - i);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      //            wr    din    rd    clr  | count empty full  af    ovf   unf   chk   dout
      vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
      vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
      vecs[2]  = '{1'b1, 8'h41, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
      vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[5]  = '{1'b1, 8'h55, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55};
      vecs[7]  = '{1'b1, 8'h66, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55};
      vecs[8]  = '{1'b1, 8'h77, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h66};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

      // Reset state
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      rst_clk_tx_n = 1'b0;
      tick();
      tick();
      check_idle_state("reset");
      check("reset.dout", fifo_bus.char_fifo_dout, 8'h00);
      check("reset.ovf",  fifo_bus.char_fifo_overflow, 0);
      check("reset.unf",  fifo_bus.char_fifo_underflow, 0);
      rst_clk_tx_n = 1'b1;
      tick();

      // Directed vector table: one edge per row
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].clr);
         tick();
         check($sformatf("v%0d.count", i), fifo_bus.char_fifo_count, vecs[i].count);
         check($sformatf("v%0d.empty", i), fifo_bus.char_fifo_empty, vecs[i].empty);
         check($sformatf("v%0d.full", i),  fifo_bus.char_fifo_full, vecs[i].full);
         check($sformatf("v%0d.af", i),    fifo_bus.char_fifo_almost_full, vecs[i].af);
         check($sformatf("v%0d.ovf", i),   fifo_bus.char_fifo_overflow, vecs[i].ovf);
         check($sformatf("v%0d.unf", i),   fifo_bus.char_fifo_underflow, vecs[i].unf);
         if (vecs[i].chk_dout) begin
            check($sformatf("v%0d.dout", i), fifo_bus.char_fifo_dout, vecs[i].dout);
         end
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);

      // Fill to DEPTH, overflow push, drain in order
      fill16(8'h00);
      drive(1'b1, 8'hFF, 1'b0, 1'b0);
      tick();
      check("ovf17.count", fifo_bus.char_fifo_count, 16);
      check("ovf17.full",  fifo_bus.char_fifo_full, 1);
      check("ovf17.ovf",   fifo_bus.char_fifo_overflow, 1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      drain(16, 8'h00, "drainA");
      check("drainA.empty", fifo_bus.char_fifo_empty, 1);
      check("drainA.full",  fifo_bus.char_fifo_full, 0);
      check("drainA.af",    fifo_bus.char_fifo_almost_full, 0);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      check("clrA.ovf", fifo_bus.char_fifo_overflow, 0);

      // Push+pop while full: pop wins, push dropped
      fill16(8'h80);
      drive(1'b1, 8'hAA, 1'b1, 1'b0);
      tick();
      check("fullpp.count", fifo_bus.char_fifo_count, 15);
      check("fullpp.full",  fifo_bus.char_fifo_full, 0);
      check("fullpp.ovf",   fifo_bus.char_fifo_overflow, 1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      drain(15, 8'h81, "drainB");
      check("drainB.empty", fifo_bus.char_fifo_empty, 1);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      check("clrB.ovf", fifo_bus.char_fifo_overflow, 0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);

      // Random push/pop stream across pointer wrap against a queue model
      begin
         logic [7:0] q[$];
         int         mcount;
         int         pushed;
         int         popped;
         int         cyc;
         logic       wr;
         logic       rd;
         mcount = 0;
         pushed = 0;
         popped = 0;
         cyc    = 0;
         while (popped < 40 && cyc < 2000) begin
            wr = (pushed < 40) && (mcount < 15) && ($urandom_range(0, 3) != 0);
            rd = (fifo_bus.char_fifo_empty == 1'b0) && ((mcount > 1) || (pushed == 40)) &&
                 ($urandom_range(0, 2) != 0);
            if (rd) begin
               if (q.size() == 0) begin
                  check($sformatf("stream.unexpected_head%0d", popped), fifo_bus.char_fifo_dout, 32'hFFFF_FFFF);
               end else begin
                  check($sformatf("stream.dout%0d", popped), fifo_bus.char_fifo_dout, q[0]);
                  void'(q.pop_front());
               end
               popped++;
            end
            drive(wr, 8'h10 + 8'(pushed), rd, 1'b0);
            tick();
            if (wr) begin
               q.push_back(8'h10 + 8'(pushed));
               pushed++;
            end
            mcount = mcount + (wr ? 1 : 0) - (rd ? 1 : 0);
            check($sformatf("stream.count_c%0d", cyc), fifo_bus.char_fifo_count, mcount);
            cyc++;
         end
         drive(1'b0, 8'h00, 1'b0, 1'b0);
         check("stream.popped", popped, 40);
         check("stream.ovf", fifo_bus.char_fifo_overflow, 0);
         check("stream.unf", fifo_bus.char_fifo_underflow, 0);
      end
      tick();

      // Asynchronous reset mid-operation discards contents
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      check("prerst.count", fifo_bus.char_fifo_count, 5);
      #2;
      rst_clk_tx_n = 1'b0;
      #1;
      check_idle_state("arst");
      check("arst.dout", fifo_bus.char_fifo_dout, 8'h00);
      tick();
      rst_clk_tx_n = 1'b1;
      drive(1'b1, 8'h7E, 1'b0, 1'b0);
      tick();
      check("postrst.count", fifo_bus.char_fifo_count, 1);
      check("postrst.empty", fifo_bus.char_fifo_empty, 1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      check("postrst.empty2", fifo_bus.char_fifo_empty, 0);
      check("postrst.dout",   fifo_bus.char_fifo_dout, 8'h7E);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      check("postrst.pop_empty", fifo_bus.char_fifo_empty, 1);
      check("postrst.pop_count", fifo_bus.char_fifo_count, 0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
